// File: rtl/tx_frame_ctrl.sv
// 802.11a PPDU bit sequencer: SIGNAL, SERVICE, DATA pass-through, TAIL and PAD
// fields emitted as one tagged bitstream toward the scrambler/encoder.
`timescale 1ns/1ps
module tx_frame_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  rate,
  input  logic [11:0] length,
  input  logic        data_in,
  input  logic        istream_val,
  output logic        istream_rdy,
  output logic        tx_bit,
  output logic        tx_val,
  input  logic        tx_rdy,
  output logic [2:0]  tx_field,
  output logic        tx_sym_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SIGNAL  = 3'd1;
  localparam logic [2:0] S_SERVICE = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_TAIL    = 3'd4;
  localparam logic [2:0] S_PAD     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [2:0] F_SIGNAL  = 3'd0;
  localparam logic [2:0] F_SERVICE = 3'd1;
  localparam logic [2:0] F_DATA    = 3'd2;
  localparam logic [2:0] F_TAIL    = 3'd3;
  localparam logic [2:0] F_PAD     = 3'd4;
  localparam logic [2:0] F_IDLE    = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [3:0]  rate_q, rate_d;
  logic [11:0] length_q, length_d;
  logic [7:0]  ndbps_q, ndbps_d;
  logic [14:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]  sbc_q, sbc_d;
  logic        err_q, err_d;

  logic [7:0]  ndbps_lut;
  logic        rate_ok;
  logic [7:0]  ndbps_last;
  logic [14:0] data_last_idx;
  logic        sym_end;
  logic        xfer;
  logic        sig_parity;
  logic [4:0]  sig_idx;
  logic [3:0]  len_idx;
  logic        sig_bit;
  logic [7:0]  sbc_inc;

  always_comb begin
    ndbps_lut = 8'd0;
    case (rate)
      4'b1101: ndbps_lut = 8'd24;
      4'b1111: ndbps_lut = 8'd36;
      4'b0101: ndbps_lut = 8'd48;
      4'b0111: ndbps_lut = 8'd72;
      4'b1001: ndbps_lut = 8'd96;
      4'b1011: ndbps_lut = 8'd144;
      4'b0001: ndbps_lut = 8'd192;
      4'b0011: ndbps_lut = 8'd216;
      default: ndbps_lut = 8'd0;
    endcase
  end

  assign rate_ok       = (ndbps_lut != 8'd0);
  assign ndbps_last    = ndbps_q - 8'd1;
  assign data_last_idx = {length_q, 3'b000} - 15'd1;
  assign sym_end       = (sbc_q == ndbps_last);
  assign sbc_inc       = sym_end ? 8'd0 : sbc_q + 8'd1;
  assign sig_parity    = ^{rate_q, length_q};

  // SIGNAL layout: R1..R4, reserved, LENGTH LSB first, parity, six tail zeros.
  assign sig_idx = bit_cnt_q[4:0];
  assign len_idx = sig_idx[3:0] - 4'd5;

  always_comb begin
    sig_bit = 1'b0;
    if (sig_idx < 5'd4) begin
      sig_bit = rate_q[2'd3 - sig_idx[1:0]];
    end else if (sig_idx >= 5'd5 && sig_idx <= 5'd16) begin
      sig_bit = length_q[len_idx];
    end else if (sig_idx == 5'd17) begin
      sig_bit = sig_parity;
    end
  end

  always_comb begin
    istream_rdy = 1'b0;
    tx_bit      = 1'b0;
    tx_val      = 1'b0;
    tx_field    = F_IDLE;
    tx_sym_last = 1'b0;
    case (state_q)
      S_SIGNAL: begin
        tx_val      = 1'b1;
        tx_bit      = sig_bit;
        tx_field    = F_SIGNAL;
        tx_sym_last = (bit_cnt_q == 15'd23);
      end
      S_SERVICE: begin
        tx_val      = 1'b1;
        tx_field    = F_SERVICE;
        tx_sym_last = sym_end;
      end
      S_DATA: begin
        istream_rdy = tx_rdy;
        tx_val      = istream_val;
        tx_bit      = data_in;
        tx_field    = F_DATA;
        tx_sym_last = sym_end;
      end
      S_TAIL: begin
        tx_val      = 1'b1;
        tx_field    = F_TAIL;
        tx_sym_last = sym_end;
      end
      S_PAD: begin
        tx_val      = 1'b1;
        tx_field    = F_PAD;
        tx_sym_last = sym_end;
      end
      default: ;
    endcase
  end

  assign xfer = tx_val && tx_rdy;

  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    length_d  = length_q;
    ndbps_d   = ndbps_q;
    bit_cnt_d = bit_cnt_q;
    sbc_d     = sbc_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (rate_ok && (length != 12'd0)) begin
            rate_d    = rate;
            length_d  = length;
            ndbps_d   = ndbps_lut;
            bit_cnt_d = 15'd0;
            sbc_d     = 8'd0;
            state_d   = S_SIGNAL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SIGNAL: begin
        if (xfer) begin
          if (bit_cnt_q == 15'd23) begin
            bit_cnt_d = 15'd0;
            sbc_d     = 8'd0;
            state_d   = S_SERVICE;
          end else begin
            bit_cnt_d = bit_cnt_q + 15'd1;
          end
        end
      end
      S_SERVICE: begin
        if (xfer) begin
          sbc_d = sbc_inc;
          if (bit_cnt_q == 15'd15) begin
            bit_cnt_d = 15'd0;
            state_d   = S_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + 15'd1;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          sbc_d = sbc_inc;
          if (bit_cnt_q == data_last_idx) begin
            bit_cnt_d = 15'd0;
            state_d   = S_TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + 15'd1;
          end
        end
      end
      S_TAIL: begin
        if (xfer) begin
          sbc_d = sbc_inc;
          if (bit_cnt_q == 15'd5) begin
            bit_cnt_d = 15'd0;
            // Tail landing exactly on a symbol boundary leaves nothing to pad.
            state_d   = sym_end ? S_DONE : S_PAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 15'd1;
          end
        end
      end
      S_PAD: begin
        if (xfer) begin
          sbc_d = sbc_inc;
          if (sym_end) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        bit_cnt_d = 15'd0;
        sbc_d     = 8'd0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rate_q    <= 4'd0;
      length_q  <= 12'd0;
      ndbps_q   <= 8'd0;
      bit_cnt_q <= 15'd0;
      sbc_q     <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rate_q    <= rate_d;
      length_q  <= length_d;
      ndbps_q   <= ndbps_d;
      bit_cnt_q <= bit_cnt_d;
      sbc_q     <= sbc_d;
      err_q     <= err_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Bench for tx_frame_ctrl: per-frame expected bit/field/symbol-end queue built
// from the field rules, checked against every transfer by one compare process.
`timescale 1ns/1ps
module tb_tx_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  rate;
  logic [11:0] length;
  logic        data_in;
  logic        istream_val;
  logic        istream_rdy;
  logic        tx_bit;
  logic        tx_val;
  logic        tx_rdy;
  logic [2:0]  tx_field;
  logic        tx_sym_last;
  logic        busy;
  logic        done;
  logic        err;

  tx_frame_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .rate(rate), .length(length),
    .data_in(data_in), .istream_val(istream_val), .istream_rdy(istream_rdy),
    .tx_bit(tx_bit), .tx_val(tx_val), .tx_rdy(tx_rdy), .tx_field(tx_field),
    .tx_sym_last(tx_sym_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       b;
    logic [2:0] f;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  int   xfer_cnt = 0;

  function automatic int ndbps_of(input logic [3:0] r);
    case (r)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  function automatic logic psdu_bit(input int k, input int pat);
    if (pat == 0) return 1'b1;
    return ((k * 37 + 11) % 5) < 2;
  endfunction

  // Expected stream for one frame, appended to exp_q.
  task automatic build_frame(input logic [3:0] r, input logic [11:0] len, input int pat);
    int   n = ndbps_of(r);
    int   l = int'(len);
    int   body = 22 + 8 * l;
    int   total;
    logic sb[24];
    logic par = 1'b0;
    exp_t e;
    for (int i = 0; i < 4; i++) sb[i] = r[3 - i];
    sb[4] = 1'b0;
    for (int i = 0; i < 12; i++) sb[5 + i] = len[i];
    for (int i = 0; i < 17; i++) par ^= sb[i];
    sb[17] = par;
    for (int i = 18; i < 24; i++) sb[i] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      e.b = sb[i]; e.f = 3'd0; e.last = (i == 23);
      exp_q.push_back(e);
    end
    total = ((body + n - 1) / n) * n;
    for (int j = 0; j < total; j++) begin
      if (j < 16)            e.f = 3'd1;
      else if (j < 16 + 8*l) e.f = 3'd2;
      else if (j < body)     e.f = 3'd3;
      else                   e.f = 3'd4;
      e.b    = (e.f == 3'd2) ? psdu_bit(j - 16, pat) : 1'b0;
      e.last = ((j % n) == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic int count_field(input logic [2:0] f);
    int c = 0;
    foreach (exp_q[i]) if (exp_q[i].f == f) c++;
    return c;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (tx_val && tx_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_xfer: unexpected transfer field %0d bit %0b", tx_field, tx_bit);
        end else begin
          cmp_e = exp_q.pop_front();
          if (tx_bit !== cmp_e.b || tx_field !== cmp_e.f || tx_sym_last !== cmp_e.last) begin
            errors++;
            $display("FAIL xfer %0d bit/field/last: got %0b/%0d/%0b expected %0b/%0d/%0b",
                     xfer_cnt, tx_bit, tx_field, tx_sym_last, cmp_e.b, cmp_e.f, cmp_e.last);
          end
        end
        xfer_cnt++;
      end
      if (!tx_rdy) begin
        checks++;
        if (istream_rdy !== 1'b0) begin
          errors++;
          $display("FAIL rdy_gate: istream_rdy got %0b expected 0 while tx_rdy=0", istream_rdy);
        end
      end
    end
  end

  // mode 0: free running, 1: tx_rdy toggling + upstream stall, 2: start pulses during DATA
  task automatic run_frame(input logic [3:0] r, input logic [11:0] len, input int pat,
                           input int mode, input int abort_at, output bit aborted);
    int   l = int'(len);
    int   idx = 0;
    int   c = 0;
    int   done_c = -1;
    int   stall_left = 0;
    bit   stalled_once = 1'b0;
    bit   busy_ok = 1'b1;
    bit   err_seen = 1'b0;
    bit   first_ok = 1'b0;
    bit   dx;
    int   n_exp;
    build_frame(r, len, pat);
    n_exp    = exp_q.size();
    xfer_cnt = 0;
    aborted  = 1'b0;
    rate = r; length = len; start = 1'b1;
    tx_rdy = 1'b1; istream_val = 1'b1; data_in = psdu_bit(0, pat);
    @(posedge clk); #1;
    start = 1'b0;
    while (done_c < 0 && c < 20000) begin
      c++;
      if (mode == 1) begin
        tx_rdy = ((xfer_cnt < 24) || (xfer_cnt >= 40 && xfer_cnt < 40 + 8*l)) ? (c % 2 == 0) : 1'b1;
        if (!stalled_once && idx == 4*l) begin
          stall_left   = 5;
          stalled_once = 1'b1;
        end
        istream_val = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      if (mode == 2) begin
        start  = (xfer_cnt >= 40 && xfer_cnt < 40 + 8*l);
        rate   = start ? 4'b1001 : r;
        length = start ? 12'd7 : len;
      end
      data_in = psdu_bit(idx, pat);
      @(negedge clk);
      dx = istream_rdy && istream_val;
      if (done) done_c = c;
      if (!busy) busy_ok = 1'b0;
      if (err) err_seen = 1'b1;
      if (c == 1) first_ok = tx_val && (tx_field == 3'd0);
      @(posedge clk); #1;
      if (dx) idx++;
      if (abort_at >= 0 && idx == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0; rate = r; length = len; tx_rdy = 1'b1; istream_val = 1'b1;
    if (aborted) begin
      $display("frame rate=%b len=%0d aborted after %0d data bits", r, l, idx);
      return;
    end
    chk("done_seen", int'(done_c >= 0), 1);
    if (mode == 0) chk("done_cycle", done_c, n_exp + 1);
    chk("first_signal_bit", int'(first_ok), 1);
    chk("busy_span", int'(busy_ok), 1);
    chk("no_err_in_frame", int'(err_seen), 0);
    chk("xfer_count", xfer_cnt, n_exp);
    chk("psdu_consumed", idx, 8*l);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 0);
    @(posedge clk); #1;
    $display("frame rate=%b len=%0d mode=%0d transfers=%0d done_cycle=%0d", r, l, mode, xfer_cnt, done_c);
    exp_q.delete();
  endtask

  task automatic reject(input logic [3:0] r, input logic [11:0] len);
    rate = r; length = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("reject_err_pulse", {30'd0, err, busy}, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reject_err_clear", {30'd0, err, busy}, 0);
    @(posedge clk); #1;
    $display("reject rate=%b len=%0d", r, len);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(nm, {22'd0, istream_rdy, tx_bit, tx_val, tx_field, tx_sym_last, busy, done, err}, 10'b0001110000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ab;
    logic [23:0] v;
    int   c, d1, d2;
    logic v74;
    logic [3:0] f75;
    reset = 1'b1; start = 1'b0; rate = 4'd0; length = 12'd0;
    data_in = 1'b0; istream_val = 1'b0; tx_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Pin the model with hand-derived values.
    build_frame(4'b1101, 12'd1, 0);
    chk("model1_size", exp_q.size(), 72);
    for (int i = 0; i < 24; i++) v[23 - i] = exp_q[i].b;
    chk("model1_signal", int'(v), 24'hD40000);
    chk("model1_pad", count_field(3'd4), 18);
    chk("model1_symlast", int'(exp_q[23].last) + int'(exp_q[47].last) + int'(exp_q[71].last), 3);
    exp_q.delete();
    build_frame(4'b0011, 12'd100, 1);
    chk("model2_size", exp_q.size(), 888);
    chk("model2_pad", count_field(3'd4), 42);
    chk("model2_data", count_field(3'd2), 800);
    chk("model2_parity", int'(exp_q[17].b), 1);
    exp_q.delete();

    run_frame(4'b1101, 12'd1, 0, 0, -1, ab);
    run_frame(4'b0011, 12'd100, 1, 0, -1, ab);
    run_frame(4'b0011, 12'd100, 1, 1, -1, ab);
    reject(4'b0000, 12'd5);
    reject(4'b1101, 12'd0);
    reject(4'b1000, 12'd3);
    run_frame(4'b1011, 12'd20, 1, 2, -1, ab);
    run_frame(4'b1111, 12'd2, 1, 0, -1, ab);
    run_frame(4'b0101, 12'd3, 1, 0, -1, ab);
    run_frame(4'b0111, 12'd9, 1, 0, -1, ab);
    run_frame(4'b0001, 12'd50, 1, 0, -1, ab);

    // Asynchronous reset part-way through DATA.
    run_frame(4'b0011, 12'd100, 1, 0, 40, ab);
    chk("abort_reached", int'(ab), 1);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_data");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    xfer_cnt = 0;
    chk_en = 1'b1;
    run_frame(4'b0011, 12'd100, 1, 0, -1, ab);

    // Back-to-back frames with start held high.
    build_frame(4'b1101, 12'd1, 0);
    build_frame(4'b1101, 12'd1, 0);
    xfer_cnt = 0;
    rate = 4'b1101; length = 12'd1; start = 1'b1;
    tx_rdy = 1'b1; istream_val = 1'b1; data_in = 1'b1;
    @(posedge clk); #1;
    c = 0; d1 = -1; d2 = -1; v74 = 1'b1; f75 = 4'd0;
    while (d2 < 0 && c < 1000) begin
      c++;
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
      if (c == 74) v74 = tx_val;
      if (c == 75) f75 = {tx_val, tx_field};
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("b2b_done1", d1, 73);
    chk("b2b_done2", d2, 147);
    chk("b2b_idle_gap", int'(v74), 0);
    chk("b2b_second_signal", int'(f75), 4'b1000);
    chk("b2b_xfers", xfer_cnt, 144);
    chk("b2b_drained", exp_q.size(), 0);
    $display("back-to-back frames done at cycles %0d and %0d", d1, d2);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_ctrl.md
# tx_frame_ctrl

Frame sequencer for the 802.11a transmit chain. On `start` it latches RATE/LENGTH and emits one PPDU bitstream to the scrambler/encoder. The stream is the 24-bit SIGNAL field, 16 SERVICE zeros, 8·LENGTH PSDU bits pulled from the upstream bit source, 6 tail zeros, and pad zeros up to an OFDM symbol boundary. It sits between the PSDU bit source (`data_in`/`istream_val`/`istream_rdy`) and the scrambler input of `top`, and tags every bit with its field so downstream stages know what to scramble and which bits to zero.

## Interface
- No parameters; N_DBPS table fixed by 802.11a.
- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-high.
- `start` in 1 — frame request; sampled in IDLE only.
- `rate` in 4 — RATE code R1..R4, `rate[3]`=R1.
- `length` in 12 — PSDU length in bytes, 1..4095.
- `data_in` in 1 — upstream PSDU bit.
- `istream_val` in 1 — upstream bit valid.
- `istream_rdy` out 1 — ready for upstream bit.
- `tx_bit` out 1 — output bit.
- `tx_val` out 1 — output bit valid.
- `tx_rdy` in 1 — downstream ready.
- `tx_field` out 3 — field tag: 0 SIGNAL, 1 SERVICE, 2 DATA, 3 TAIL, 4 PAD, 7 idle.
- `tx_sym_last` out 1 — current bit is the last of an OFDM symbol.
- `busy` out 1 — frame in progress.
- `done` out 1 — one-cycle pulse after the final bit transfers.
- `err` out 1 — one-cycle pulse when `start` is rejected.

## Operation
- Transfer occurs on a rising edge when `tx_val && tx_rdy`. All counters advance only on a transfer.
- States: IDLE → SIGNAL → SERVICE → DATA → TAIL → PAD → DONE → IDLE.
- In IDLE, `start`=1 with a valid rate and `length`≠0 latches `rate`, `length`, and N_DBPS, then enters SIGNAL.
  - Invalid rate or `length`=0: `err` pulses next cycle and the block stays in IDLE.
- N_DBPS by rate code: 1101→24, 1111→36, 0101→48, 0111→72, 1001→96, 1011→144, 0001→192, 0011→216. Any other code is invalid.
- SIGNAL: 24 bits, transmitted in this order:
  - R1..R4.
  - Reserved 0.
  - LENGTH bits 0..11, LSB first.
  - Even parity over the preceding 17 bits.
  - Six zeros.
  - `tx_sym_last`=1 on bit 23.
- SERVICE: 16 zeros. The symbol bit counter `sbc` (8 bits) clears on entry to SERVICE and increments per transfer, wrapping N_DBPS−1→0. `tx_sym_last`=1 when `sbc`=N_DBPS−1 in SERVICE through PAD.
- DATA: pass-through of 8·LENGTH bits.
  - `tx_bit`=`data_in`, `tx_val`=`istream_val`, `istream_rdy`=`tx_rdy`.
  - The bit counter (15 bits) ends the state on transfer of bit 8·LENGTH−1.
- TAIL: 6 zeros.
- PAD: zeros until the transfer with `sbc`=N_DBPS−1.
  - If TAIL ends with `sbc` wrapped to 0, PAD is skipped and the sequencer goes directly to DONE.
  - Pad count = N_SYM·N_DBPS − (22+8·LENGTH), which is always ≥2 for legal rates. The skip path must still be implemented.
- DONE: one cycle, `done`=1, then IDLE.
- Outside DATA, `istream_rdy`=0 and `tx_bit` is combinational from state/counters. `tx_val`=1 in SIGNAL, SERVICE, TAIL, and PAD.
- `start` while `busy` is ignored. No `err` pulse is issued.
- `reset` mid-frame: immediate return to IDLE, all counters cleared, latched values cleared, no `done`.

## Timing
- Reset values:
  - `istream_rdy`=0, `tx_bit`=0, `tx_val`=0.
  - `tx_field`=7, `tx_sym_last`=0.
  - `busy`=0, `done`=0, `err`=0.
- `start` accepted at edge k → SIGNAL bit 0 presented with `tx_val`=1 in cycle k+1. `busy`=1 from k+1 through the DONE cycle.
- Zero-latency pass-through in DATA: `istream_rdy`, `tx_val`, and `tx_bit` are combinational from the same-cycle inputs. There is no internal buffering.
- With `tx_rdy` held at 1 and `istream_val` held at 1, total bits = 24 + N_SYM·N_DBPS. One bit transfers per cycle. `done` is asserted the cycle after the last transfer.
- Backpressure: while `tx_rdy`=0, all state, `tx_bit`, and `tx_field` are held stable.
- Upstream stall in DATA: `tx_val`=0 and counters hold.
- `tx_field` changes only on the transfer edge that completes a field.

## Test plan
- Rate 1101, length 1, all upstream bits 1, rdy always high:
  - SIGNAL = 1,1,0,1,0,1, eleven 0s, parity 0, six 0s.
  - Then 16×0, 8×1, 6×0, 18 pad zeros.
  - 72 transfers total, `tx_sym_last` at transfers 24, 48, and 72, `done` at cycle 73 after start.
- Rate 0011, length 100: 800 DATA bits, 42 PAD bits, 888 transfers total. SIGNAL parity bit = 1.
- Backpressure: toggle `tx_rdy` 1/0 each cycle during SIGNAL and DATA, and drop `istream_val` for 5 cycles mid-DATA → bit sequence identical to the unstalled run, `istream_rdy`=0 whenever `tx_rdy`=0.
- Rejects:
  - `start` with rate 0000 → `err` pulse, `busy` stays 0.
  - `start` with length 0 → `err` pulse, `busy` stays 0.
  - `start` during DATA → ignored, frame unaffected.
- Reset asserted asynchronously mid-DATA (bit 40 of 800) → all outputs take their reset values before the next edge. A new `start` then produces a correct full frame.
- Back-to-back frames: `start` held high with rate 1101 / length 1 → second SIGNAL bit 0 appears the cycle after DONE+IDLE, and both frames are identical.
